alu_sequencer: RTL and testbench

- Job-level controller for the 16-bit accumulator ALU (load / ADD / MUL, one-cycle update, out_val lagging acc by one cycle).
- Accepts a stream of command beats (LOAD, ADD, MUL) over a valid/ready handshake and issues them to the ALU one per cycle.
- Inserts the drain cycles the ALU pipeline needs and returns the final accumulator value over a second valid/ready handshake.
- Sits between the instruction front-end and the ALU instance, and owns the ALU's control pins.

---
 rtl/alu_sequencer.sv | 106 ++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: job-level controller feeding command beats to the accumulator ALU and returning its result
module alu_sequencer #(
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_MUL = 4'h2,
    parameter logic [3:0] OP_NOP = 4'hF,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [15:0]      cmd_data,
    input  logic             cmd_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] res_beats,
    output logic             busy,
    output logic             alu_rst_n,
    output logic             alu_load,
    output logic [15:0]      alu_in,
    output logic [3:0]       alu_op,
    input  logic [15:0]      alu_out
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DRAIN3, DONE} state_t;
    state_t state_q, state_d;
    logic             alu_load_q, alu_load_d;
    logic [15:0]      alu_in_q, alu_in_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [15:0]      res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] res_beats_q, res_beats_d;
    logic             accept, bad, good, job_end;
    assign accept    = cmd_valid & cmd_ready;
    // a first beat that is not LOAD, or the reserved opcode, is issued as NOP and flags the job
    assign bad       = (cmd_op == 2'b11) | ((state_q == IDLE) & (cmd_op != 2'b00));
    assign good      = accept & ~bad;
    assign job_end   = (state_q == DONE) & res_ready;
    assign alu_rst_n = ~rst;
    assign alu_load  = alu_load_q;
    assign alu_in    = alu_in_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign res_beats = res_beats_q;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next state: run until the last beat, then three fixed drain cycles cover the ALU pipeline
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN: state_d = accept ? (cmd_last ? DRAIN1 : RUN) : state_q;
            DRAIN1:    state_d = DRAIN2;
            DRAIN2:    state_d = DRAIN3;
            DRAIN3:    state_d = DONE;
            DONE:      state_d = res_ready ? IDLE : DONE;
            default:   state_d = IDLE;
        endcase
    end
    // state-decoded handshake outputs
    always_comb begin
        cmd_ready = (state_q == IDLE) | (state_q == RUN);
        res_valid = state_q == DONE;
        busy      = state_q != IDLE;
    end
    // datapath next values: ALU pins carry an accepted beat for one cycle only, NOP otherwise
    always_comb begin
        alu_load_d  = good & (cmd_op == 2'b00);
        alu_in_d    = accept ? cmd_data : alu_in_q;
        alu_op_d    = (good & (cmd_op == 2'b01)) ? OP_ADD : (good & (cmd_op == 2'b10)) ? OP_MUL : OP_NOP;
        cnt_d       = job_end ? '0 : (accept & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d       = job_end ? 1'b0 : err_q | (accept & bad);
        res_data_d  = (state_q == DRAIN3) ? alu_out : res_data_q;
        res_err_d   = (state_q == DRAIN3) ? err_q : res_err_q;
        res_beats_d = (state_q == DRAIN3) ? cnt_q : res_beats_q;
    end
    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_load_q  <= 1'b0;
            alu_in_q    <= '0;
            alu_op_q    <= OP_NOP;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_beats_q <= '0;
        end else begin
            alu_load_q  <= alu_load_d;
            alu_in_q    <= alu_in_d;
            alu_op_q    <= alu_op_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_beats_q <= res_beats_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven, directed and randomized checks of alu_sequencer against a bench ALU
module tb_alu_sequencer;
    localparam logic [1:0] LD = 2'b00, AD = 2'b01, MU = 2'b10, RS = 2'b11;
    logic clk, rst, cmd_valid, cmd_ready, cmd_last, res_valid, res_ready, res_err, busy;
    logic alu_rst_n, alu_load;
    logic [1:0] cmd_op;
    logic [15:0] cmd_data, res_data, alu_in, alu_out, alu_acc;
    logic [7:0] res_beats;
    logic [3:0] alu_op;
    int n_cmp = 0, n_bad = 0;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .res_beats(res_beats), .busy(busy),
        .alu_rst_n(alu_rst_n), .alu_load(alu_load), .alu_in(alu_in), .alu_op(alu_op), .alu_out(alu_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // accumulator ALU: one-cycle update, out_val lags acc by one cycle
    always @(posedge clk) begin
        if (!alu_rst_n) begin
            alu_acc <= 16'd0;
            alu_out <= 16'd0;
        end else begin
            alu_acc <= alu_load ? alu_in : (alu_op == 4'h1) ? alu_acc + alu_in : (alu_op == 4'h2) ? alu_acc * alu_in : alu_acc;
            alu_out <= alu_acc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [1:0] op, input logic [15:0] d, input logic last, input int gap);
        int n = 0;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_op = op; cmd_data = d; cmd_last = last;
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_last = 0;
    endtask

    task automatic get_result(input int hold, output logic [15:0] d, output logic e, output logic [7:0] b, output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!res_valid) chk("drain_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
        d = res_data; e = res_err; b = res_beats;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(d));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1;
        @(posedge clk);
        #1;
        res_ready = 0;
        chk("exit_valid", 32'(res_valid), 32'd0);
        chk("exit_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        int n;
        logic [0:3][1:0] op;
        logic [0:3][15:0] d;
        logic [15:0] ed;
        logic ee;
        logic [7:0] eb;
    } job_t;
    job_t jobs[8];
    logic [15:0] rd, m_acc;
    logic re, m_err, seen;
    logic [7:0] rb;
    int lat, nb;
    logic [1:0] rop;
    logic [15:0] rdat;
    logic bad;

    initial begin
        jobs[0] = '{n:3, op:{LD, AD, MU, LD}, d:{16'd3, 16'd4, 16'd5, 16'd0}, ed:16'd35, ee:1'b0, eb:8'd3};
        jobs[1] = '{n:1, op:{LD, LD, LD, LD}, d:{16'h1234, 16'd0, 16'd0, 16'd0}, ed:16'h1234, ee:1'b0, eb:8'd1};
        jobs[2] = '{n:3, op:{LD, RS, AD, LD}, d:{16'd2, 16'd9, 16'd1, 16'd0}, ed:16'd3, ee:1'b1, eb:8'd3};
        jobs[3] = '{n:1, op:{AD, LD, LD, LD}, d:{16'd7, 16'd0, 16'd0, 16'd0}, ed:16'd3, ee:1'b1, eb:8'd1};
        jobs[4] = '{n:2, op:{LD, AD, LD, LD}, d:{16'hFFFF, 16'd2, 16'd0, 16'd0}, ed:16'd1, ee:1'b0, eb:8'd2};
        jobs[5] = '{n:2, op:{LD, MU, LD, LD}, d:{16'h00FF, 16'h0101, 16'd0, 16'd0}, ed:16'hFFFF, ee:1'b0, eb:8'd2};
        jobs[6] = '{n:3, op:{LD, MU, AD, LD}, d:{16'h0100, 16'h0100, 16'h0007, 16'd0}, ed:16'h0007, ee:1'b0, eb:8'd3};
        jobs[7] = '{n:4, op:{LD, MU, AD, RS}, d:{16'd5, 16'd3, 16'd1, 16'd4}, ed:16'd16, ee:1'b1, eb:8'd4};
        rst = 1; cmd_valid = 0; cmd_op = LD; cmd_data = 0; cmd_last = 0; res_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_res_beats", 32'(res_beats), 32'd0);
        chk("rst_alu_load", 32'(alu_load), 32'd0);
        chk("rst_alu_in", 32'(alu_in), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 0;
        @(negedge clk);
        chk("alu_rst_n_release", 32'(alu_rst_n), 32'd1);

        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < jobs[j].n; i++) beat(jobs[j].op[i], jobs[j].d[i], i == jobs[j].n - 1, 0);
            get_result(0, rd, re, rb, lat);
            chk($sformatf("job%0d_data", j), 32'(rd), 32'(jobs[j].ed));
            chk($sformatf("job%0d_err", j), 32'(re), 32'(jobs[j].ee));
            chk($sformatf("job%0d_beats", j), 32'(rb), 32'(jobs[j].eb));
            chk($sformatf("job%0d_latency", j), 32'(lat), 32'd4);
        end

        beat(LD, 16'h1234, 1, 0);
        chk("single_load_on", 32'(alu_load), 32'd1);
        chk("single_alu_in", 32'(alu_in), 32'h1234);
        @(posedge clk);
        #1;
        chk("single_load_off", 32'(alu_load), 32'd0);
        chk("single_op_nop", 32'(alu_op), 32'hF);
        get_result(0, rd, re, rb, lat);
        chk("single_data", 32'(rd), 32'h1234);
        chk("single_beats", 32'(rb), 32'd1);

        beat(LD, 16'h0100, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("gap_op_nop", 32'(alu_op), 32'hF);
            chk("gap_load_off", 32'(alu_load), 32'd0);
        end
        beat(MU, 16'h0100, 0, 0);
        chk("gap_mul_op", 32'(alu_op), 32'h2);
        beat(AD, 16'h0007, 1, 0);
        chk("gap_add_op", 32'(alu_op), 32'h1);
        get_result(0, rd, re, rb, lat);
        chk("gap_data", 32'(rd), 32'h0007);

        beat(LD, 16'h0055, 0, 0);
        beat(AD, 16'h0001, 1, 0);
        get_result(5, rd, re, rb, lat);
        chk("bp_data", 32'(rd), 32'h0056);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        beat(LD, 16'd9, 1, 0);
        get_result(0, rd, re, rb, lat);
        chk("bp_next_data", 32'(rd), 32'd9);
        chk("bp_next_err", 32'(re), 32'd0);

        beat(LD, 16'd1, 0, 0);
        for (int k = 0; k < 259; k++) beat(AD, 16'd0, k == 258, 0);
        get_result(0, rd, re, rb, lat);
        chk("sat_data", 32'(rd), 32'd1);
        chk("sat_beats", 32'(rb), 32'd255);

        beat(LD, 16'd5, 0, 0);
        beat(AD, 16'd1, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_data", 32'(res_data), 32'd0);
        chk("midrst_res_err", 32'(res_err), 32'd0);
        chk("midrst_res_beats", 32'(res_beats), 32'd0);
        chk("midrst_alu_load", 32'(alu_load), 32'd0);
        chk("midrst_alu_in", 32'(alu_in), 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'hF);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        beat(LD, 16'd1, 0, 0);
        beat(AD, 16'd1, 1, 0);
        get_result(0, rd, re, rb, lat);
        chk("midrst_next_data", 32'(rd), 32'd2);
        m_acc = 16'd2;

        for (int j = 0; j < 40; j++) begin
            nb = $urandom_range(1, 6);
            m_err = 0;
            for (int i = 0; i < nb; i++) begin
                rop = (i == 0) ? (($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : LD) : 2'($urandom_range(0, 3));
                rdat = 16'($urandom);
                bad = (rop == RS) || (i == 0 && rop != LD);
                m_err = m_err | bad;
                if (!bad) m_acc = (rop == LD) ? rdat : (rop == AD) ? m_acc + rdat : m_acc * rdat;
                beat(rop, rdat, i == nb - 1, $urandom_range(0, 2));
            end
            get_result($urandom_range(0, 3), rd, re, rb, lat);
            chk($sformatf("rnd%0d_data", j), 32'(rd), 32'(m_acc));
            chk($sformatf("rnd%0d_err", j), 32'(re), 32'(m_err));
            chk($sformatf("rnd%0d_beats", j), 32'(rb), 32'(nb));
            chk($sformatf("rnd%0d_latency", j), 32'(lat), 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
